// File: rtl/ninjakun_gfx_rom_arb.sv
// Shares one 32-bit graphics ROM read port among the FG, BG and sprite fetchers.
// Define GFX_ARB_RR_EN for round-robin grant; the default is fixed priority FG > BG > SP.
module ninjakun_gfx_rom_arb #(
    parameter int unsigned       MEM_AW  = 16,
    parameter logic [MEM_AW-1:0] FG_BASE = 16'h0000,
    parameter logic [MEM_AW-1:0] BG_BASE = 16'h2000,
    parameter logic [MEM_AW-1:0] SP_BASE = 16'h6000
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [12:0]       fg_addr,
    output logic [31:0]       fg_data,
    input  logic [13:0]       bg_addr,
    output logic [31:0]       bg_data,
    input  logic [13:0]       sp_addr,
    output logic [31:0]       sp_data,
    output logic              sp_rdy,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [1:0] {CH_FG = 2'd0, CH_BG = 2'd1, CH_SP = 2'd2} chan_t;

    state_t            state, state_nxt;
    chan_t             gnt, win;
    logic [12:0]       srv_addr_fg;
    logic [13:0]       srv_addr_bg, srv_addr_sp;
    logic [2:0]        srv_vld;
    logic [13:0]       req_addr;
    logic [2:0]        pend;
    logic              any_pend;
    logic              grant, done;
    logic [13:0]       win_addr;
    logic [MEM_AW-1:0] win_mem_addr;

    // Compared against the live inputs, so a change during WAIT re-requests on return.
    assign pend[0]  = !srv_vld[0] || (fg_addr != srv_addr_fg);
    assign pend[1]  = !srv_vld[1] || (bg_addr != srv_addr_bg);
    assign pend[2]  = !srv_vld[2] || (sp_addr != srv_addr_sp);
    assign any_pend = |pend;

    assign grant = (state == ST_IDLE) && any_pend;
    assign done  = (state == ST_WAIT) && mem_ack;

    assign sp_rdy = srv_vld[2] && (sp_addr == srv_addr_sp) && !((state == ST_WAIT) && (gnt == CH_SP));

`ifdef GFX_ARB_RR_EN
    chan_t      rr_ptr;
    logic [2:0] rr_idx;
    logic       rr_found;

    always_comb begin
        win      = CH_FG;
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            rr_idx = {1'b0, rr_ptr} + 3'(i);
            if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
            if (!rr_found && pend[rr_idx[1:0]]) begin
                win      = chan_t'(rr_idx[1:0]);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET)      rr_ptr <= CH_FG;
        else if (grant) rr_ptr <= win;
    end
`else
    always_comb begin
        win = CH_FG;
        if (pend[0])      win = CH_FG;
        else if (pend[1]) win = CH_BG;
        else if (pend[2]) win = CH_SP;
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        win_addr     = {1'b0, fg_addr};
        win_mem_addr = FG_BASE + MEM_AW'(fg_addr);
        case (win)
            CH_BG: begin
                win_addr     = bg_addr;
                win_mem_addr = BG_BASE + MEM_AW'(bg_addr);
            end
            CH_SP: begin
                win_addr     = sp_addr;
                win_mem_addr = SP_BASE + MEM_AW'(sp_addr);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_pend) state_nxt = ST_WAIT;
            ST_WAIT: if (mem_ack)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of order.
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            gnt         <= CH_FG;
            req_addr    <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            srv_vld     <= '0;
            srv_addr_fg <= '0;
            srv_addr_bg <= '0;
            srv_addr_sp <= '0;
            fg_data     <= '0;
            bg_data     <= '0;
            sp_data     <= '0;
        end else if (grant) begin
            gnt      <= win;
            req_addr <= win_addr;
            mem_addr <= win_mem_addr;
            mem_req  <= 1'b1;
        end else if (done) begin
            mem_req <= 1'b0;
            // The latched request address is recorded, not the live input.
            case (gnt)
                CH_FG: begin
                    fg_data     <= mem_data;
                    srv_addr_fg <= req_addr[12:0];
                    srv_vld[0]  <= 1'b1;
                end
                CH_BG: begin
                    bg_data     <= mem_data;
                    srv_addr_bg <= req_addr;
                    srv_vld[1]  <= 1'b1;
                end
                CH_SP: begin
                    sp_data     <= mem_data;
                    srv_addr_sp <= req_addr;
                    srv_vld[2]  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ninjakun_gfx_rom_arb.sv
// Scoreboard bench for ninjakun_gfx_rom_arb: expected request addresses are queued by the
// stimulus, a monitor pops them on each new mem_req; a latency-3 memory model answers.
module tb_ninjakun_gfx_rom_arb;

    localparam int LAT = 3;

    logic        MCLK, RESET;
    logic [12:0] fg_addr;
    logic [13:0] bg_addr, sp_addr;
    logic [31:0] fg_data, bg_data, sp_data;
    logic        sp_rdy, mem_req, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;

    logic        mem_en, man_pulse;
    logic [31:0] man_data;
    int          lat_cnt;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    ninjakun_gfx_rom_arb dut (
        .MCLK(MCLK), .RESET(RESET),
        .fg_addr(fg_addr), .fg_data(fg_data),
        .bg_addr(bg_addr), .bg_data(bg_data),
        .sp_addr(sp_addr), .sp_data(sp_data), .sp_rdy(sp_rdy),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    function automatic logic [31:0] data_for(input logic [15:0] a);
        if (a == 16'h0123) return 32'hDEADBEEF;
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Memory model: answers each request LAT cycles after it is first seen.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        lat_cnt  = -1;
        forever begin
            @(posedge MCLK);
            #1;
            mem_ack = 1'b0;
            if (man_pulse) begin
                mem_ack  = 1'b1;
                mem_data = man_data;
                lat_cnt  = -1;
            end else if (!mem_en) begin
                lat_cnt = -1;
            end else if (lat_cnt < 0) begin
                if (mem_req) lat_cnt = LAT - 1;
            end else if (lat_cnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = data_for(mem_addr);
                lat_cnt  = -1;
            end else begin
                lat_cnt--;
            end
        end
    end

    // Monitor: every rising mem_req must match the oldest queued expectation.
    initial begin
        logic prev_req;
        logic [15:0] exp_addr;
        prev_req = 1'b0;
        forever begin
            @(negedge MCLK);
            if (mem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_req: got mem_addr %h, want no request", mem_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    check("req_addr", 32'(mem_addr), 32'(exp_addr));
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_ack(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge MCLK);
            if (mem_ack) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL %s: got no mem_ack in 50 cycles, want one", name);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge MCLK);
            if (mem_req) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL %s: got no mem_req in 50 cycles, want one", name);
    endtask

    initial begin
        RESET     = 1'b1;
        fg_addr   = '0;
        bg_addr   = '0;
        sp_addr   = '0;
        mem_en    = 1'b1;
        man_pulse = 1'b0;
        man_data  = '0;

        // Reset state, then three cold-start fetches in priority order.
        repeat (3) @(negedge MCLK);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_fg_data", fg_data, 32'd0);
        check("rst_sp_data", sp_data, 32'd0);
        check("rst_sp_rdy", 32'(sp_rdy), 32'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h6000);
        RESET = 1'b0;
        wait_ack("cold_fg");
        wait_ack("cold_bg");
        wait_ack("cold_sp");
        check("cold_sp_rdy_ack_cycle", 32'(sp_rdy), 32'd0);
        @(negedge MCLK);
        check("cold_sp_rdy", 32'(sp_rdy), 32'd1);
        check("cold_fg_data", fg_data, 32'hFFFF0000);
        check("cold_bg_data", bg_data, 32'hDFFF2000);
        check("cold_sp_data", sp_data, 32'h9FFF6000);

        // Single FG fetch, then silence while the address is held.
        exp_q.push_back(16'h0123);
        fg_addr = 13'h0123;
        wait_ack("fg_single");
        @(negedge MCLK);
        check("fg_single_data", fg_data, 32'hDEADBEEF);
        repeat (10) @(negedge MCLK);
        check("fg_single_quiet", 32'(exp_q.size()), 32'd0);

        // SP address changes during its own WAIT: stale word stored, re-request follows.
        exp_q.push_back(16'h6010);
        sp_addr = 14'h0010;
        #1;
        check("sp_rdy_drop_same_cycle", 32'(sp_rdy), 32'd0);
        wait_req("sp_first_req");
        sp_addr = 14'h0011;
        exp_q.push_back(16'h6011);
        wait_ack("sp_first_ack");
        @(negedge MCLK);
        check("sp_stale_data", sp_data, 32'h9FEF6010);
        check("sp_stale_rdy", 32'(sp_rdy), 32'd0);
        wait_ack("sp_second_ack");
        @(negedge MCLK);
        check("sp_fresh_data", sp_data, 32'h9FEE6011);
        check("sp_fresh_rdy", 32'(sp_rdy), 32'd1);

        // FG changes after every transfer: SP waits until FG stops.
        exp_q.push_back(16'h0100);
        fg_addr = 13'h0100;
        sp_addr = 14'h0020;
        for (int k = 0; k < 4; k++) begin
            wait_ack("starve_fg");
            if (k < 3) begin
                fg_addr = 13'((k + 2) * 'h100);
                exp_q.push_back(16'((k + 2) * 'h100));
            end
        end
        exp_q.push_back(16'h6020);
        wait_ack("starve_sp");
        @(negedge MCLK);
        check("starve_fg_data", fg_data, 32'hFBFF0400);
        check("starve_sp_data", sp_data, 32'h9FDF6020);
        check("starve_sp_rdy", 32'(sp_rdy), 32'd1);

        // Reset during WAIT; the late ack coincides with reset and is dropped.
        mem_en = 1'b0;
        exp_q.push_back(16'h2005);
        bg_addr = 14'h0005;
        wait_req("abandon_req");
        RESET = 1'b1;
        @(negedge MCLK);
        check("abandon_mem_req", 32'(mem_req), 32'd0);
        check("abandon_fg_data", fg_data, 32'd0);
        check("abandon_sp_rdy", 32'(sp_rdy), 32'd0);
        man_data  = 32'h12345678;
        man_pulse = 1'b1;
        exp_q.push_back(16'h0400);
        exp_q.push_back(16'h2005);
        exp_q.push_back(16'h6020);
        @(negedge MCLK);
        man_pulse = 1'b0;
        mem_en    = 1'b1;
        RESET     = 1'b0;
        @(negedge MCLK);
        check("abandon_bg_data", bg_data, 32'd0);
        check("abandon_fg_data2", fg_data, 32'd0);
        wait_ack("refetch_fg");
        wait_ack("refetch_bg");
        wait_ack("refetch_sp");
        @(negedge MCLK);
        check("refetch_fg_data", fg_data, 32'hFBFF0400);
        check("refetch_bg_data", bg_data, 32'hDFFA2005);
        check("refetch_sp_data", sp_data, 32'h9FDF6020);

        // Stray ack in IDLE: nothing moves.
        mem_en    = 1'b0;
        man_data  = 32'hCAFEF00D;
        man_pulse = 1'b1;
        @(negedge MCLK);
        man_pulse = 1'b0;
        @(negedge MCLK);
        check("stray_fg_data", fg_data, 32'hFBFF0400);
        check("stray_bg_data", bg_data, 32'hDFFA2005);
        check("stray_sp_data", sp_data, 32'h9FDF6020);
        check("stray_mem_req", 32'(mem_req), 32'd0);
        check("stray_sp_rdy", 32'(sp_rdy), 32'd1);
        repeat (5) @(negedge MCLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
